sdram_port_arbiter: RTL and testbench
=====================================

// Module: sdram_port_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single 16-bit SDRAM controller slave (sdram_wire side) among
//  NUM_REQ Avalon-MM requesters (display refresh, key/switch logger, DMA helpers).
//  Sits between the requesters and the SDRAM controller's s1 port. Allows one transaction in
//  flight at a time; read data is routed back to the granted requester.
// PARAMETERS
//  NUM_REQ      4    number of requesters (2..8)
//  ADDR_W       25   word address width to SDRAM controller
//  DATA_W       16   data width (matches sdram_wire_dq)
//  TIMEOUT_CYC  1024 read-wait watchdog limit, cycles (used only with SDRAM_ARB_TIMEOUT_EN)
// PORTS
//  clk_clk            in   1                  system clock
//  reset_reset        in   1                  synchronous reset, active-high
//  req_read           in   NUM_REQ            per-requester read strobe
//  req_write          in   NUM_REQ            per-requester write strobe
//  req_address        in   NUM_REQ*ADDR_W     packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//  req_writedata      in   NUM_REQ*DATA_W     packed write data
//  req_byteenable     in   NUM_REQ*DATA_W/8   packed byte enables
//  req_waitrequest    out  NUM_REQ            per-requester stall
//  req_readdata       out  DATA_W             shared read data bus, qualified by req_readdatavalid
//  req_readdatavalid  out  NUM_REQ            one-cycle read return pulse to owner
//  avm_read           out  1                  to SDRAM controller
//  avm_write          out  1
//  avm_address        out  ADDR_W
//  avm_writedata      out  DATA_W
//  avm_byteenable     out  DATA_W/8
//  avm_waitrequest    in   1
//  avm_readdata       in   DATA_W
//  avm_readdatavalid  in   1
//  grant              out  NUM_REQ            one-hot current owner, 0 when idle
//  timeout_err        out  1                  sticky watchdog flag
// BEHAVIOUR
//  Reset: state=IDLE, grant=0, last_grant=NUM_REQ-1 (requester 0 has top priority), avm_read/write=0,
//   req_waitrequest=all 1, req_readdatavalid=0, timeout_err=0. Reset mid-transaction aborts to IDLE.
//  FSM IDLE -> ISSUE -> (WAIT_RD) -> IDLE.
//  IDLE: pending = req_read|req_write. If nonzero, register first set bit searching from last_grant+1
//   with wrap; go ISSUE. Command appears on avm_* the cycle after the request is sampled.
//  ISSUE: avm_* = granted requester's signals; avm_write takes priority if read and write both set.
//   req_waitrequest[g]=avm_waitrequest, all others 1. On acceptance (strobe & !avm_waitrequest):
//   last_grant<=g; write -> IDLE; read -> WAIT_RD. Granted requester drops both strobes -> IDLE, nothing issued.
//  WAIT_RD: avm_read/write=0, all req_waitrequest=1. On avm_readdatavalid: req_readdata=avm_readdata,
//   req_readdatavalid[g]=1 for that cycle only, grant<=0, -> IDLE.
//  avm_readdatavalid outside WAIT_RD is ignored (covers stale returns after reset).
//  grant is 0 in IDLE, one-hot in ISSUE/WAIT_RD. Back-to-back: min 2 cycles per write, no idle bubble
//   beyond the IDLE arbitration cycle.
// CONFIGURATION
//  SDRAM_ARB_TIMEOUT_EN defined: counter cleared on entering WAIT_RD, increments each WAIT_RD cycle;
//   reaching TIMEOUT_CYC with no readdatavalid -> req_readdatavalid[g]=1, req_readdata={DATA_W{1'b1}},
//   timeout_err<=1 (sticky until reset), -> IDLE.
//  Not defined: WAIT_RD waits indefinitely, no counter logic, timeout_err tied 0.
// TESTING
//  1 req0 read addr 0x100; slave waitreq 2 cycles, data 0xBEEF 3 cycles later -> avm_address=0x100,
//    one avm_read accepted, req_readdatavalid=4'b0001 one cycle, req_readdata=0xBEEF.
//  2 all 4 request writes same cycle after reset -> avm_write issued for requesters 0,1,2,3 in order,
//    exactly one each, grant sequence 0001,0010,0100,1000.
//  3 req0 writes continuously, req2 pulses one write -> order 0,2,0 (no starvation).
//  4 reset_reset during WAIT_RD -> next cycle grant=0, avm_read=0, req_waitrequest=4'b1111;
//    late avm_readdatavalid produces no req_readdatavalid.
//  5 with SDRAM_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, slave never returns -> after 16 WAIT_RD cycles
//    req_readdatavalid pulse, data 0xFFFF, timeout_err=1; without macro remains in WAIT_RD.
//  6 req1 write 0x5A5A, byteenable 2'b01 -> avm_writedata=0x5A5A, avm_byteenable=2'b01 unchanged.

Source files
------------

// File: rtl/sdram_port_arbiter_if.sv
// Avalon-MM bundle between the requesters and the SDRAM controller s1 port.
// The slave modport is the arbiter's view; master is the requester/controller side.
interface sdram_port_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 25,
    parameter int DATA_W  = 16
);
    logic [NUM_REQ-1:0]          req_read;
    logic [NUM_REQ-1:0]          req_write;
    logic [NUM_REQ*ADDR_W-1:0]   req_address;
    logic [NUM_REQ*DATA_W-1:0]   req_writedata;
    logic [NUM_REQ*DATA_W/8-1:0] req_byteenable;
    logic [NUM_REQ-1:0]          req_waitrequest;
    logic [DATA_W-1:0]           req_readdata;
    logic [NUM_REQ-1:0]          req_readdatavalid;
    logic                        avm_read;
    logic                        avm_write;
    logic [ADDR_W-1:0]           avm_address;
    logic [DATA_W-1:0]           avm_writedata;
    logic [DATA_W/8-1:0]         avm_byteenable;
    logic                        avm_waitrequest;
    logic [DATA_W-1:0]           avm_readdata;
    logic                        avm_readdatavalid;

    modport slave (
        input  req_read, req_write, req_address,
        input  req_writedata, req_byteenable,
        output req_waitrequest, req_readdata, req_readdatavalid,
        output avm_read, avm_write, avm_address,
        output avm_writedata, avm_byteenable,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid
    );

    modport master (
        output req_read, req_write, req_address,
        output req_writedata, req_byteenable,
        input  req_waitrequest, req_readdata, req_readdatavalid,
        input  avm_read, avm_write, avm_address,
        input  avm_writedata, avm_byteenable,
        output avm_waitrequest, avm_readdata, avm_readdatavalid
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port, one transaction in flight.
// Optional read watchdog: define SDRAM_ARB_TIMEOUT_EN.
module sdram_port_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 25,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    sdram_port_arbiter_if.slave  bus,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 timeout_err
);
    localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BE_W = DATA_W / 8;

    if (NUM_REQ < 2 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("sdram_port_arbiter: NUM_REQ must be >= 2, TIMEOUT_CYC >= 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] gidx, gidx_nx;
    logic [IW-1:0] last, last_nx;
    logic [IW-1:0] pick, idx;
    logic          found;
    logic          sel_rd, sel_wr;
    logic          to_hit;
    logic [NUM_REQ-1:0] pending;

    assign pending = bus.req_read | bus.req_write;
    assign sel_rd  = bus.req_read[gidx];
    assign sel_wr  = bus.req_write[gidx];

    assign bus.avm_address    = bus.req_address[gidx*ADDR_W +: ADDR_W];
    assign bus.avm_writedata  = bus.req_writedata[gidx*DATA_W +: DATA_W];
    assign bus.avm_byteenable = bus.req_byteenable[gidx*BE_W +: BE_W];

    assign grant = (state == IDLE) ? '0 : (NUM_REQ'(1) << gidx);

    // First pending requester after the last one served, wrapping around.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IW'((int'(last) + k) % NUM_REQ);
            if (!found && pending[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx              = state;
        gidx_nx               = gidx;
        last_nx               = last;
        bus.avm_read          = 1'b0;
        bus.avm_write         = 1'b0;
        bus.req_waitrequest   = '1;
        bus.req_readdatavalid = '0;
        bus.req_readdata      = bus.avm_readdata;
        unique case (state)
            IDLE: begin
                if (found) begin
                    gidx_nx  = pick;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                bus.avm_write             = sel_wr;
                bus.avm_read              = sel_rd & ~sel_wr;
                bus.req_waitrequest[gidx] = bus.avm_waitrequest;
                if (!(sel_rd | sel_wr)) begin
                    state_nx = IDLE;
                end else if (!bus.avm_waitrequest) begin
                    last_nx  = gidx;
                    state_nx = sel_wr ? IDLE : WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (bus.avm_readdatavalid) begin
                    bus.req_readdatavalid[gidx] = 1'b1;
                    state_nx = IDLE;
                end else if (to_hit) begin
                    bus.req_readdatavalid[gidx] = 1'b1;
                    bus.req_readdata            = '1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state <= IDLE;
            gidx  <= '0;
            last  <= IW'(NUM_REQ - 1);
        end else begin
            state <= state_nx;
            gidx  <= gidx_nx;
            last  <= last_nx;
        end
    end

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] to_cnt;
    logic          to_err_q;

    // Counter sits at zero outside WAIT_RD, so every read starts fresh.
    assign to_hit      = (state == WAIT_RD) && (to_cnt == CW'(TIMEOUT_CYC - 1));
    assign timeout_err = to_err_q;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            to_cnt   <= '0;
            to_err_q <= 1'b0;
        end else begin
            to_cnt <= (state == WAIT_RD) ? to_cnt + 1'b1 : '0;
            if (to_hit && !bus.avm_readdatavalid) begin
                to_err_q <= 1'b1;
            end
        end
    end
`else
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: directed scenarios plus random traffic
// against a memory-backed reference of the requester/controller transactions.
module tb_sdram_port_arbiter;
    localparam int NR = 4;
    localparam int AW = 25;
    localparam int DW = 16;
    localparam int BW = 2;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [BW-1:0] be;
        int            dly;
    } txn_t;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } ret_t;

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
    } rexp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NR-1:0] grant;
    logic timeout_err;

    always #5 clk = ~clk;

    sdram_port_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    sdram_port_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(16)
    ) dut (
        .clk_clk(clk),
        .reset_reset(rst),
        .bus(bus),
        .grant(grant),
        .timeout_err(timeout_err)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    txn_t  stim_q [NR][$];
    txn_t  exp_cmd[NR][$];
    txn_t  cur    [NR];
    bit    act    [NR];
    bit    acc    [NR];
    int    dly_cnt[NR];
    int    exp_order[$];
    rexp_t rd_exp[$];
    ret_t  ret_q[$];
    logic [DW-1:0] mem [int];

    bit rand_mode = 0;
    bit to_mode   = 0;
    bit force_rdv = 0;
    int stall_n   = 0;
    int fixed_lat = 1;
    int hold_cnt  = 0;

    task automatic chk(string nm, logic [31:0] actual, logic [31:0] req);
        checks++;
        if (actual !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, actual, req);
        end
    endtask

    function automatic logic [DW-1:0] mem_rd(logic [AW-1:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return a[DW-1:0] ^ 16'hA5C3;
    endfunction

    function automatic bit busy();
        for (int i = 0; i < NR; i++)
            if (act[i] || stim_q[i].size() > 0 || exp_cmd[i].size() > 0) return 1;
        return rd_exp.size() > 0;
    endfunction

    task automatic push(int i, bit wr, int a, logic [DW-1:0] d, logic [BW-1:0] be, int dly);
        txn_t t;
        t.wr = wr; t.addr = AW'(a); t.data = d; t.be = be; t.dly = dly;
        stim_q[i].push_back(t);
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NR; i++) begin
            bus.req_read[i]                = act[i] && !cur[i].wr;
            bus.req_write[i]               = act[i] && cur[i].wr;
            bus.req_address[i*AW +: AW]    = cur[i].addr;
            bus.req_writedata[i*DW +: DW]  = cur[i].data;
            bus.req_byteenable[i*BW +: BW] = cur[i].be;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NR; i++) begin
            if (act[i] && acc[i]) act[i] = 0;
            if (!act[i] && stim_q[i].size() > 0) begin
                if (dly_cnt[i] < stim_q[i][0].dly) begin
                    dly_cnt[i]++;
                end else begin
                    dly_cnt[i] = 0;
                    cur[i] = stim_q[i].pop_front();
                    act[i] = 1;
                    exp_cmd[i].push_back(cur[i]);
                end
            end
        end
        drive_reqs();
        bus.avm_waitrequest = rand_mode ? ($urandom_range(0, 2) == 0) : (hold_cnt < stall_n);
        if (force_rdv) begin
            bus.avm_readdatavalid = 1'b1;
            bus.avm_readdata      = 16'h1234;
        end else if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
            bus.avm_readdatavalid = 1'b1;
            bus.avm_readdata      = ret_q.pop_front().data;
        end else begin
            bus.avm_readdatavalid = 1'b0;
            bus.avm_readdata      = DW'($urandom);
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < NR; i++) begin
            act[i] = 0;
            dly_cnt[i] = 0;
            stim_q[i].delete();
            exp_cmd[i].delete();
        end
        exp_order.delete();
        rd_exp.delete();
        ret_q.delete();
        force_rdv = 0;
        drive_reqs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_all();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain(string nm, int lim);
        int n = 0;
        while (busy() && n < lim) begin
            step();
            n++;
        end
        checks++;
        if (busy()) begin
            failures++;
            $display("FAIL %s_drain actual=busy required=idle after %0d cycles", nm, lim);
        end
        step();
        step();
    endtask

    task automatic wait_accept(int i, string nm);
        int n = 0;
        while ((stim_q[i].size() > 0 || exp_cmd[i].size() > 0) && n < 50) begin
            step();
            n++;
        end
        chk({nm, "_accept"}, exp_cmd[i].size(), 0);
    endtask

    // Monitor: predicts the controller side from the requester queues.
    initial begin
        int    gi, ri;
        txn_t  t;
        rexp_t e;
        ret_t  r;
        logic [DW-1:0] nv;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NR; i++)
                acc[i] = (bus.req_read[i] | bus.req_write[i]) && !bus.req_waitrequest[i];
            if (rst) begin
                hold_cnt = 0;
                continue;
            end
            if ((bus.avm_read || bus.avm_write) && !bus.avm_waitrequest) begin
                gi = -1;
                for (int i = 0; i < NR; i++) if (grant[i]) gi = i;
                chk("grant_onehot", 32'($onehot(grant)), 1);
                chk("rd_wr_excl", 32'(bus.avm_read & bus.avm_write), 0);
                chk("others_wait", 32'(bus.req_waitrequest | grant), (1 << NR) - 1);
                if (exp_order.size() > 0) chk("grant_order", gi, exp_order.pop_front());
                if (gi < 0 || exp_cmd[gi].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_cmd actual=grant %b required=none", grant);
                end else begin
                    t = exp_cmd[gi].pop_front();
                    chk("cmd_kind", 32'(bus.avm_write), 32'(t.wr));
                    chk("cmd_addr", 32'(bus.avm_address), 32'(t.addr));
                    if (t.wr) begin
                        chk("cmd_wdata", 32'(bus.avm_writedata), 32'(t.data));
                        chk("cmd_be", 32'(bus.avm_byteenable), 32'(t.be));
                        nv = mem_rd(t.addr);
                        if (t.be[0]) nv[7:0]  = t.data[7:0];
                        if (t.be[1]) nv[15:8] = t.data[15:8];
                        mem[int'(t.addr)] = nv;
                    end else begin
                        e.idx  = gi;
                        e.data = to_mode ? 16'hFFFF : mem_rd(t.addr);
                        rd_exp.push_back(e);
                        r.due  = cyc + (rand_mode ? int'($urandom_range(1, 4)) : fixed_lat);
                        r.data = mem_rd(t.addr);
                        ret_q.push_back(r);
                    end
                end
                hold_cnt = 0;
            end else if (bus.avm_read || bus.avm_write) begin
                hold_cnt++;
            end
            if (|bus.req_readdatavalid) begin
                ri = -1;
                for (int i = 0; i < NR; i++) if (bus.req_readdatavalid[i]) ri = i;
                chk("rdv_onehot", 32'($onehot(bus.req_readdatavalid)), 1);
                if (rd_exp.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_rdv actual=%b required=0", bus.req_readdatavalid);
                end else begin
                    e = rd_exp.pop_front();
                    chk("rd_owner", ri, e.idx);
                    chk("rd_data", 32'(bus.req_readdata), 32'(e.data));
                end
            end
        end
    end

    initial begin
        bus.avm_waitrequest   = 1'b0;
        bus.avm_readdata      = '0;
        bus.avm_readdatavalid = 1'b0;
        for (int i = 0; i < NR; i++) begin
            cur[i] = '{wr: 1'b0, addr: '0, data: '0, be: '0, dly: 0};
            acc[i] = 0;
        end
        do_reset();
        @(negedge clk);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_avm_read", 32'(bus.avm_read), 0);
        chk("rst_avm_write", 32'(bus.avm_write), 0);
        chk("rst_waitreq", 32'(bus.req_waitrequest), 32'hF);
        chk("rst_rdv", 32'(bus.req_readdatavalid), 0);
        chk("rst_timeout", 32'(timeout_err), 0);

        // Single read with controller stall and latency
        mem[256] = 16'hBEEF;
        stall_n = 2; fixed_lat = 3;
        push(0, 0, 'h100, '0, 2'b11, 0);
        drain("t1", 100);

        // All four write at once straight after reset
        do_reset();
        stall_n = 1; fixed_lat = 2;
        for (int i = 0; i < NR; i++) begin
            push(i, 1, 'h10 + i, DW'(16'h1000 + i), 2'b11, 0);
            exp_order.push_back(i);
        end
        drain("t2", 100);

        // Continuous writer must not starve a one-shot writer
        stall_n = 0;
        push(0, 1, 'h20, 16'hAAAA, 2'b11, 0);
        push(0, 1, 'h21, 16'hBBBB, 2'b11, 0);
        push(0, 1, 'h22, 16'hCCCC, 2'b11, 0);
        push(2, 1, 'h30, 16'hDDDD, 2'b11, 1);
        exp_order = '{0, 2, 0, 0};
        drain("t3", 100);

        // Partial byte enable passes through unchanged
        push(1, 1, 'h33, 16'h5A5A, 2'b01, 0);
        push(1, 0, 'h33, '0, 2'b11, 0);
        drain("t6", 100);

        // Random traffic
        rand_mode = 1;
        for (int i = 0; i < NR; i++)
            for (int n = 0; n < 40; n++)
                push(i, bit'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                     DW'($urandom), BW'($urandom_range(1, 3)), int'($urandom_range(0, 3)));
        drain("rand", 20000);
        rand_mode = 0;

        // Reset while a read is outstanding
        do_reset();
        stall_n = 0; fixed_lat = 1000;
        push(1, 0, 'h40, '0, 2'b11, 0);
        wait_accept(1, "t4");
        step();
        step();
        @(negedge clk);
        chk("t4_wait_grant", 32'(grant), 32'b0010);
        chk("t4_wait_avm_read", 32'(bus.avm_read), 0);
        step();
        rst = 1'b1;
        clear_all();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t4_grant", 32'(grant), 0);
        chk("t4_avm_read", 32'(bus.avm_read), 0);
        chk("t4_waitreq", 32'(bus.req_waitrequest), 32'hF);
        force_rdv = 1;
        step();
        force_rdv = 0;
        @(negedge clk);
        chk("t4_late_rdv", 32'(bus.req_readdatavalid), 0);
        step();

        // Controller never returns read data
        do_reset();
`ifdef SDRAM_ARB_TIMEOUT_EN
        to_mode = 1;
        push(3, 0, 'h7, '0, 2'b11, 0);
        drain("t5", 60);
        @(negedge clk);
        chk("t5_timeout_err", 32'(timeout_err), 1);
        to_mode = 0;
`else
        push(3, 0, 'h7, '0, 2'b11, 0);
        wait_accept(3, "t5");
        repeat (40) step();
        @(negedge clk);
        chk("t5_still_wait", 32'(grant), 32'b1000);
        chk("t5_no_return", rd_exp.size(), 1);
        chk("t5_timeout_err", 32'(timeout_err), 0);
`endif
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
